// File: rtl/df_sink_pkg.sv
// df_sink_pkg: shared types and helpers for the dataflow sink.
// Holds the run-control state encoding and the FIFO pointer-width helper.
package df_sink_pkg;

    // Run-control states of the sink
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sink_state_t;

    // Pointer width: one extra MSB beyond the address bits separates full from empty
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/df_sink_if.sv
// df_sink_if: token input, run control, status and host read port of the sink.
// The master modport is the environment side, the slave modport is df_sink.
interface df_sink_if #(
    parameter int N     = 16,
    parameter int CNT_W = 16
);
    logic             EN;
    logic             START;
    logic [CNT_W-1:0] EXPECT;
    logic             R_IN;
    logic [N-1:0]     D_IN;
    logic             RD_VALID;
    logic [N-1:0]     RD_DATA;
    logic             RD_READY;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] COUNT;
    logic             OVF;

    modport master (
        output EN, START, EXPECT, R_IN, D_IN, RD_READY,
        input  RD_VALID, RD_DATA, BUSY, DONE, COUNT, OVF
    );

    modport slave (
        input  EN, START, EXPECT, R_IN, D_IN, RD_READY,
        output RD_VALID, RD_DATA, BUSY, DONE, COUNT, OVF
    );
endinterface

// File: rtl/df_sink_fifo.sv
// df_sink_fifo: small synchronous FIFO used as the sink's token buffer.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module df_sink_fifo
    import df_sink_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [N-1:0] head
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [N-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values: flush empties the FIFO, otherwise advance on push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/df_sink.sv
// df_sink: terminal consumer of the operator dataflow fabric.
// Captures result tokens into a FIFO, exposes them on a valid/ready read port
// and tracks a run of EXPECT tokens through IDLE/RUN/DRAIN/DONE.
// Optional feature macro: DF_SINK_OVERFLOW_EN builds the sticky OVF flag.
module df_sink
    import df_sink_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic       CLK,
    input logic       RST,
    df_sink_if.slave  bus
);
    sink_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] expect_q, expect_d;
    logic             start_acc;
    logic             arrival;
    logic             last_token;
    logic             fifo_full;
    logic             fifo_empty;
    logic [N-1:0]     fifo_head;

    assign arrival    = (state_q == ST_RUN) & bus.EN & bus.R_IN;
    assign last_token = arrival && ((count_q + 1'b1) == expect_q);

    df_sink_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (arrival),
        .push_data (bus.D_IN),
        .pop       (bus.RD_READY),
        .flush     (start_acc),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Next-state logic for run control; START is only honoured when not busy
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    start_acc = 1'b1;
                    state_d   = (bus.EXPECT == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_token) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the token counter and latched expected count
    always_comb begin
        count_d  = count_q;
        expect_d = expect_q;
        if (start_acc) begin
            expect_d = bus.EXPECT;
            count_d  = '0;
        end else if (arrival && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    // State and counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            expect_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            expect_q <= expect_d;
        end
    end

`ifdef DF_SINK_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic drop;

    assign drop = arrival & fifo_full & ~bus.RD_READY;

    // Sticky overflow flag: set on a dropped token, cleared by an accepted START
    always_comb begin
        ovf_d = ovf_q;
        if (start_acc) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.OVF = ovf_q;
`else
    assign bus.OVF = 1'b0;
`endif

    assign bus.RD_VALID = ~fifo_empty;
    assign bus.RD_DATA  = fifo_empty ? '0 : fifo_head;
    assign bus.BUSY     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.DONE     = (state_q == ST_DONE);
    assign bus.COUNT    = count_q;

endmodule

// File: tb/tb_df_sink.sv
// tb_df_sink: scoreboard bench for df_sink.
// Written tokens are queued as they are driven; a monitor pops and compares
// each time the host side completes a read handshake.
module tb_df_sink;
    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

`ifdef DF_SINK_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic CLK;
    logic RST;

    df_sink_if #(.N(N), .CNT_W(CNT_W)) bus ();

    df_sink #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [N-1:0] expQ [$];

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle of input; strobes are released afterwards
    task automatic applyStimulus(input logic en, input logic rin, input logic [N-1:0] din,
                                 input logic start, input logic [CNT_W-1:0] expCount);
        bus.EN     = en;
        bus.R_IN   = rin;
        bus.D_IN   = din;
        bus.START  = start;
        bus.EXPECT = expCount;
        tick();
        bus.R_IN  = 1'b0;
        bus.START = 1'b0;
    endtask

    task automatic sendToken(input logic [N-1:0] din, input bit written);
        if (written) expQ.push_back(din);
        applyStimulus(1'b1, 1'b1, din, 1'b0, '0);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!bus.DONE && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_reached", {31'd0, bus.DONE}, 32'd1);
    endtask

    // Monitor: compare every popped head against the scoreboard
    initial begin
        logic [N-1:0] exp;
        forever begin
            @(negedge CLK);
            if (!RST && bus.RD_VALID && bus.RD_READY) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL rd_data: got 0x%0h, expected no data", bus.RD_DATA);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("rd_data", {16'd0, bus.RD_DATA}, {16'd0, exp});
                end
            end
        end
    end

    initial begin
        RST          = 1'b1;
        bus.EN       = 1'b0;
        bus.START    = 1'b0;
        bus.EXPECT   = '0;
        bus.R_IN     = 1'b0;
        bus.D_IN     = '0;
        bus.RD_READY = 1'b0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_rd_valid", {31'd0, bus.RD_VALID}, 32'd0);
        checkOutput("rst_busy",     {31'd0, bus.BUSY},     32'd0);
        checkOutput("rst_done",     {31'd0, bus.DONE},     32'd0);
        checkOutput("rst_count",    {16'd0, bus.COUNT},    32'd0);
        checkOutput("rst_ovf",      {31'd0, bus.OVF},      32'd0);
        RST = 1'b0;
        tick();

        $display("[TB] basic run of four tokens");
        bus.RD_READY = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd4);
        checkOutput("t1_busy_after_start", {31'd0, bus.BUSY}, 32'd1);
        checkOutput("t1_count_cleared",    {16'd0, bus.COUNT}, 32'd0);
        sendToken(16'h0011, 1'b1);
        sendToken(16'h0022, 1'b1);
        sendToken(16'h0033, 1'b1);
        sendToken(16'h0044, 1'b1);
        checkOutput("t1_count",      {16'd0, bus.COUNT}, 32'd4);
        checkOutput("t1_drain_busy", {31'd0, bus.BUSY},  32'd1);
        checkOutput("t1_drain_done", {31'd0, bus.DONE},  32'd0);
        tick();
        checkOutput("t1_not_done_yet", {31'd0, bus.DONE}, 32'd0);
        tick();
        checkOutput("t1_done",  {31'd0, bus.DONE}, 32'd1);
        checkOutput("t1_busy",  {31'd0, bus.BUSY}, 32'd0);
        checkOutput("t1_ovf",   {31'd0, bus.OVF},  32'd0);
        checkOutput("t1_queue", expQ.size(), 32'd0);

        $display("[TB] overflow run: ten tokens into eight entries");
        bus.RD_READY = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd10);
        for (int i = 0; i < 10; i++) sendToken(16'h0100 + 16'(i), i < DEPTH);
        checkOutput("t2_count",    {16'd0, bus.COUNT},    32'd10);
        checkOutput("t2_busy",     {31'd0, bus.BUSY},     32'd1);
        checkOutput("t2_done",     {31'd0, bus.DONE},     32'd0);
        checkOutput("t2_rd_valid", {31'd0, bus.RD_VALID}, 32'd1);
        checkOutput("t2_ovf",      {31'd0, bus.OVF},      {31'd0, OVF_EXP});
        bus.RD_READY = 1'b1;
        waitDone(20);
        checkOutput("t2_queue", expQ.size(), 32'd0);
        checkOutput("t2_ovf_held", {31'd0, bus.OVF}, {31'd0, OVF_EXP});

        $display("[TB] full FIFO with push and pop together");
        bus.RD_READY = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd9);
        checkOutput("t3_ovf_cleared", {31'd0, bus.OVF}, 32'd0);
        for (int i = 0; i < DEPTH; i++) sendToken(16'h0200 + 16'(i), 1'b1);
        bus.RD_READY = 1'b1;
        sendToken(16'h0208, 1'b1);
        checkOutput("t3_count", {16'd0, bus.COUNT}, 32'd9);
        checkOutput("t3_ovf",   {31'd0, bus.OVF},   32'd0);
        waitDone(20);
        checkOutput("t3_queue", expQ.size(), 32'd0);

        $display("[TB] EN gating and START while busy");
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, '0);
        checkOutput("t4_count_gated", {16'd0, bus.COUNT},    32'd0);
        checkOutput("t4_fifo_empty",  {31'd0, bus.RD_VALID}, 32'd0);
        sendToken(16'h0301, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd1);
        checkOutput("t4_start_ignored_count", {16'd0, bus.COUNT}, 32'd1);
        checkOutput("t4_start_ignored_busy",  {31'd0, bus.BUSY},  32'd1);
        sendToken(16'h0302, 1'b1);
        sendToken(16'h0303, 1'b1);
        waitDone(20);
        checkOutput("t4_count", {16'd0, bus.COUNT}, 32'd3);

        $display("[TB] START with EXPECT of zero");
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd0);
        checkOutput("t5_done",  {31'd0, bus.DONE},  32'd1);
        checkOutput("t5_busy",  {31'd0, bus.BUSY},  32'd0);
        checkOutput("t5_count", {16'd0, bus.COUNT}, 32'd0);
        tick();
        checkOutput("t5_busy_later", {31'd0, bus.BUSY}, 32'd0);

        $display("[TB] reset in the middle of a run");
        bus.RD_READY = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 16'd5);
        sendToken(16'h0401, 1'b1);
        sendToken(16'h0402, 1'b1);
        sendToken(16'h0403, 1'b1);
        checkOutput("t6_count_before", {16'd0, bus.COUNT},    32'd3);
        checkOutput("t6_valid_before", {31'd0, bus.RD_VALID}, 32'd1);
        RST = 1'b1;
        tick();
        checkOutput("t6_rd_valid", {31'd0, bus.RD_VALID}, 32'd0);
        checkOutput("t6_busy",     {31'd0, bus.BUSY},     32'd0);
        checkOutput("t6_done",     {31'd0, bus.DONE},     32'd0);
        checkOutput("t6_count",    {16'd0, bus.COUNT},    32'd0);
        checkOutput("t6_ovf",      {31'd0, bus.OVF},      32'd0);
        expQ.delete();
        RST = 1'b0;
        tick();
        checkOutput("t6_idle_busy", {31'd0, bus.BUSY}, 32'd0);

        checkOutput("final_queue", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/df_sink.md
# df_sink

Terminal consumer for the operator dataflow fabric. Captures result tokens (one-cycle R strobe plus N-bit data, no backpressure) from the last operator of a graph, buffers them in a small FIFO, and presents them to the host side over a valid/ready read port. Run control (START, expected token count, BUSY/DONE) lets the controller know when a graph evaluation has fully drained.

## Interface
- N, 16, token data width
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, 16, width of expected/received token counters
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  input-side enable; tokens captured only when EN=1
- START  in  1  one-cycle pulse: begin a run
- EXPECT  in  CNT_W  tokens expected this run; sampled on accepted START
- R_IN  in  1  token strobe from upstream operator
- D_IN  in  N  token data, valid when R_IN=1
- RD_VALID  out  1  FIFO head valid
- RD_DATA  out  N  FIFO head data
- RD_READY  in  1  host pops head when RD_VALID & RD_READY
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  high in DONE state
- COUNT  out  CNT_W  tokens arrived this run (accepted plus dropped)
- OVF  out  1  sticky overflow flag (see Configuration)

## Operation
- FSM states IDLE, RUN, DRAIN, DONE. Reset: IDLE, FIFO empty, COUNT=0, all outputs 0.
- IDLE/DONE + START: latch EXPECT, clear COUNT and OVF, flush FIFO; EXPECT=0 -> DONE, else -> RUN. START in RUN/DRAIN ignored.
- Token arrives when state=RUN & EN & R_IN. Each arrival increments COUNT. Arrival with FIFO not full, or full with simultaneous pop, is written; full without pop is dropped.
- RUN -> DRAIN on the arrival that makes COUNT equal to the latched EXPECT (that token is processed normally).
- DRAIN -> DONE when FIFO empty and no write pending. If the final token enters an empty FIFO, DRAIN lasts until it is popped.
- DONE holds until next START. Tokens outside RUN are ignored; COUNT does not change.
- Read side is not gated by EN, and pops are honoured in any state. RD_VALID = FIFO not empty; RD_DATA = head entry, stable while RD_VALID & !RD_READY.
- COUNT saturates at all-ones. It cannot wrap because RUN exits at EXPECT.
- FIFO pointers are log2(DEPTH)+1 bits wide. The MSB distinguishes full from empty, and the pointers wrap naturally.

## Timing
- Write latency 1: token at cycle t into empty FIFO -> RD_VALID=1, RD_DATA=D_IN at t+1.
- Pop at cycle t -> next entry (or RD_VALID=0) at t+1.
- Simultaneous push and pop: occupancy unchanged, both take effect.
- START accepted at t -> BUSY=1 (or DONE=1 if EXPECT=0) at t+1. Tokens are eligible from t+1.
- Last token at t -> BUSY stays 1 and DONE=0 at t+1 (DRAIN). DONE=1 the cycle after the FIFO becomes empty.
- RST mid-run: next cycle IDLE, FIFO empty, all outputs 0.

## Configuration
- DF_SINK_OVERFLOW_EN defined:
  - OVF is set on any dropped token and stays set until START or RST.
  - Set and clear in the same cycle: START wins.
- DF_SINK_OVERFLOW_EN undefined:
  - OVF is tied 0 and no flag logic is built.
  - Drops still occur and still count toward COUNT.

## Structure
- Package df_sink_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - pointer-width function clog2-based on DEPTH
- Sub-module df_sink_fifo:
  - parameters N, DEPTH
  - ports push, push_data, pop, flush, full, empty, head
  - no FSM knowledge
- df_sink owns the FSM, counters and OVF.

## Test plan
- EXPECT=4, EN=1, tokens 0x0011,0x0022,0x0033,0x0044 on consecutive cycles, RD_READY=1 -> RD_DATA sequence matches, COUNT=4, DONE=1 one cycle after last pop, OVF=0.
- DEPTH=8, EXPECT=10, RD_READY=0, 10 tokens -> FIFO holds the first 8, COUNT=10, OVF=1 (macro on) or 0 (macro off), state DRAIN; then RD_READY=1 -> 8 pops, then DONE.
- FIFO full, token plus pop in the same cycle -> token written, no drop, OVF stays 0.
- EN=0 with R_IN pulses in RUN -> COUNT unchanged, FIFO empty. START while BUSY -> ignored.
- START with EXPECT=0 -> DONE=1 next cycle, BUSY never asserted.
- RST asserted mid-RUN with 3 entries buffered -> next cycle RD_VALID=0, BUSY=0, DONE=0, COUNT=0, OVF=0.
